// File: rtl/seq_mult_param.sv
// Parametrised shift-add multiplier: one multiplier bit per clock, signed/unsigned per operation.
// Define MULT_EARLY_TERM_EN to stop as soon as the remaining multiplier bits are all zero.
module seq_mult_param #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 rdy,
    output logic                 done
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t               state_reg;
    logic [2*WIDTH-1:0]   mc_reg;
    logic [2*WIDTH-1:0]   acc_reg;
    logic [WIDTH-1:0]     mq_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic                 sign_neg_reg;

    logic [WIDTH-1:0]     x_mag;
    logic [WIDTH-1:0]     y_mag;
    logic [WIDTH-1:0]     mq_next;
    logic                 run_last;
    logic                 skip_run;

    // The most negative value maps to 2^(W-1), which still fits as an unsigned W-bit magnitude.
    assign x_mag   = (signed_mode && multiplicand[WIDTH-1]) ? (~multiplicand + ONE_W) : multiplicand;
    assign y_mag   = (signed_mode && multiplier[WIDTH-1])   ? (~multiplier + ONE_W)   : multiplier;
    assign mq_next = mq_reg >> 1;

`ifdef MULT_EARLY_TERM_EN
    assign run_last = (cnt_reg == CNT_W'(1)) || (mq_next == '0);
    assign skip_run = (x_mag == '0) || (y_mag == '0);
`else
    assign run_last = (cnt_reg == CNT_W'(1));
    assign skip_run = 1'b0;
`endif

    assign rdy = (state_reg == S_IDLE);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg    <= S_IDLE;
            mc_reg       <= '0;
            acc_reg      <= '0;
            mq_reg       <= '0;
            cnt_reg      <= '0;
            sign_neg_reg <= 1'b0;
            product      <= '0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        sign_neg_reg <= signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                        mc_reg       <= {{WIDTH{1'b0}}, x_mag};
                        mq_reg       <= y_mag;
                        acc_reg      <= '0;
                        cnt_reg      <= CNT_W'(WIDTH);
                        state_reg    <= skip_run ? S_FIX : S_RUN;
                    end
                end
                S_RUN: begin
                    if (mq_reg[0]) begin
                        acc_reg <= acc_reg + mc_reg;
                    end
                    mc_reg  <= mc_reg << 1;
                    mq_reg  <= mq_next;
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (run_last) begin
                        state_reg <= S_FIX;
                    end
                end
                S_FIX: begin
                    // Negating a zero accumulator yields zero, so no -0 case exists.
                    product   <= sign_neg_reg ? (~acc_reg + ONE_2W) : acc_reg;
                    done      <= 1'b1;
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_mult_param.sv
// Scoreboard bench for seq_mult_param: directed W=8 cases plus a random W=16 sweep.
module tb_seq_mult_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_b;
    logic        start8, sm8, rdy8, done8;
    logic [7:0]  x8, y8;
    logic [15:0] p8;
    logic        start16, sm16, rdy16, done16;
    logic [15:0] x16, y16;
    logic [31:0] p16;

    seq_mult_param #(.WIDTH(8)) u8 (
        .clk(clk), .rst_b(rst_b), .start(start8), .signed_mode(sm8),
        .multiplicand(x8), .multiplier(y8), .product(p8), .rdy(rdy8), .done(done8)
    );
    seq_mult_param #(.WIDTH(16)) u16 (
        .clk(clk), .rst_b(rst_b), .start(start16), .signed_mode(sm16),
        .multiplicand(x16), .multiplier(y16), .product(p16), .rdy(rdy16), .done(done16)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        longint prod;
        int     t0;
        int     n;
    } exp_t;
    exp_t q8[$];
    exp_t q16[$];

    // Reference: plain integer product of the interpreted operands; N from the operand magnitudes.
    function automatic void model(input int w, input bit sm, input longint x, input longint y,
                                  output longint p, output int n);
        longint xs, ys, mask;
        mask = (longint'(1) << (2 * w)) - 1;
        xs = (sm && (((x >> (w - 1)) & 1) != 0)) ? x - (longint'(1) << w) : x;
        ys = (sm && (((y >> (w - 1)) & 1) != 0)) ? y - (longint'(1) << w) : y;
        p  = (xs * ys) & mask;
`ifdef MULT_EARLY_TERM_EN
        begin
            longint ax, ay;
            ax = (xs < 0) ? -xs : xs;
            ay = (ys < 0) ? -ys : ys;
            n = 0;
            if (ax != 0) begin
                while (ay != 0) begin
                    n++;
                    ay = ay >> 1;
                end
            end
        end
`else
        n = w;
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp_v);
        total++;
        if (got !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp_v);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_b && done8) begin
            if (q8.size() == 0) begin
                total++;
                bad++;
                $display("FAIL u8 unexpected done: product %0h expected no result", p8);
            end else begin
                e = q8.pop_front();
                chk("u8 product", 64'(p8), 64'(e.prod));
                chk("u8 latency", 64'(cyc - e.t0), 64'(e.n + 2));
                chk("u8 rdy with done", 64'(rdy8), 64'(1));
                $display("u8  result %04h latency %0d", p8, cyc - e.t0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_b && done16) begin
            if (q16.size() == 0) begin
                total++;
                bad++;
                $display("FAIL u16 unexpected done: product %0h expected no result", p16);
            end else begin
                e = q16.pop_front();
                chk("u16 product", 64'(p16), 64'(e.prod));
                chk("u16 latency", 64'(cyc - e.t0), 64'(e.n + 2));
                $display("u16 result %08h latency %0d", p16, cyc - e.t0);
            end
        end
    end

    task automatic issue8(input bit sm, input logic [7:0] x, input logic [7:0] y,
                          input bit chk_b2b, output int t0);
        int guard = 0;
        longint p;
        int n;
        while (!rdy8 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!rdy8) begin
            total++;
            bad++;
            $display("FAIL u8 rdy timeout: rdy %0b expected 1", rdy8);
        end
        if (chk_b2b) chk("u8 b2b done", 64'(done8), 64'(1));
        model(8, sm, longint'(x), longint'(y), p, n);
        t0 = cyc;
        q8.push_back('{prod: p, t0: cyc, n: n});
        sm8 = sm; x8 = x; y8 = y; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        sm8 = 1'($urandom); x8 = 8'($urandom); y8 = 8'($urandom);
    endtask

    task automatic issue16(input bit sm, input logic [15:0] x, input logic [15:0] y);
        int guard = 0;
        longint p;
        int n;
        while (!rdy16 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!rdy16) begin
            total++;
            bad++;
            $display("FAIL u16 rdy timeout: rdy %0b expected 1", rdy16);
        end
        model(16, sm, longint'(x), longint'(y), p, n);
        q16.push_back('{prod: p, t0: cyc, n: n});
        sm16 = sm; x16 = x; y16 = y; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        sm16 = 1'($urandom); x16 = 16'($urandom); y16 = 16'($urandom);
    endtask

    initial begin
        int t0;
        int guard;
        bit sm;
        logic [15:0] a, b;
        rst_b = 1'b0;
        start8 = 1'b0; sm8 = 1'b0; x8 = '0; y8 = '0;
        start16 = 1'b0; sm16 = 1'b0; x16 = '0; y16 = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset product", 64'(p8), 64'(0));
        chk("reset done", 64'(done8), 64'(0));
        chk("reset rdy", 64'(rdy8), 64'(1));
        chk("reset product16", 64'(p16), 64'(0));
        rst_b = 1'b1;
        @(negedge clk);

        issue8(1'b0, 8'd13, 8'd11, 1'b0, t0);
        // A start pulse while busy must be ignored.
        @(negedge clk);
        chk("busy rdy", 64'(rdy8), 64'(0));
        start8 = 1'b1; x8 = 8'($urandom); y8 = 8'($urandom);
        @(negedge clk);
        start8 = 1'b0;

        issue8(1'b0, 8'd255, 8'd255, 1'b0, t0);
        issue8(1'b1, 8'h80, 8'h7F, 1'b0, t0);
        issue8(1'b1, 8'h80, 8'h80, 1'b0, t0);
        issue8(1'b0, 8'd0, 8'd200, 1'b0, t0);
        issue8(1'b0, 8'd37, 8'd0, 1'b0, t0);
        issue8(1'b1, 8'hFB, 8'd0, 1'b0, t0);
        issue8(1'b1, 8'd3, 8'hFC, 1'b1, t0);

        // Abandon an operation at S_RUN cycle 3.
        issue8(1'b0, 8'd100, 8'hC3, 1'b0, t0);
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b0;
        q8.delete();
        #1;
        chk("midrun product", 64'(p8), 64'(0));
        chk("midrun done", 64'(done8), 64'(0));
        chk("midrun rdy", 64'(rdy8), 64'(1));
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        issue8(1'b0, 8'd6, 8'd7, 1'b0, t0);

        for (int i = 0; i < 40; i++) begin
            sm = 1'($urandom);
            a  = 16'($urandom);
            b  = 16'($urandom);
            if (i == 0) begin sm = 1'b1; a = 16'h8000; b = 16'h8000; end
            if (i == 1) begin b = 16'h0000; end
            if (i == 2) begin b = 16'h0001; end
            if (i == 3) begin sm = 1'b1; a = 16'hFFFF; b = 16'h7FFF; end
            issue16(sm, a, b);
        end

        guard = 0;
        while ((q8.size() != 0 || q16.size() != 0) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (q8.size() != 0 || q16.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending u8 %0d u16 %0d expected 0", q8.size(), q16.size());
        end
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
